// File: rtl/frame_recenter.sv
// Re-centres a frame whose first VSHIFT lines were consumed upstream: drops those
// lines, then appends VSHIFT synthetic lines and blanks a BORDER-wide frame edge.
module frame_recenter #(
  parameter int unsigned    COL        = 640,
  parameter int unsigned    ROW        = 480,
  parameter int unsigned    DW         = 24,
  parameter int unsigned    VSHIFT     = 1,
  parameter int unsigned    BORDER     = 1,
  parameter int unsigned    FLUSH_GAP  = 100,
  parameter int unsigned    HGAP       = 16,
  parameter logic [DW-1:0]  BORDER_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_de,
  input  logic [DW-1:0] i_data,
  output logic          o_de,
  output logic [DW-1:0] o_data,
  output logic          o_pair_en,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_err
);

  typedef enum logic [1:0] {PASS, GAP, FLUSH, HBLK} state_t;

  localparam logic [15:0] COL_M1  = 16'(COL - 1);
  localparam logic [15:0] ROW_M1  = 16'(ROW - 1);
  localparam logic [15:0] GAP_M1  = 16'(FLUSH_GAP - 1);
  localparam logic [15:0] HGAP_M1 = 16'(HGAP - 1);
  localparam logic [15:0] H_HI    = 16'(COL - BORDER);
  localparam logic [15:0] V_HI    = 16'(ROW - BORDER);

  state_t        state;
  logic [15:0]   in_col, in_row, cnt, syn_cnt, out_h, out_v;
  logic          s1_vld, s1_err;
  logic [DW-1:0] s1_data;
  logic          row_skip, more_syn, border;

  // "+1 <=" forms keep the compares well-formed when VSHIFT or BORDER is 0
  always_comb begin
    row_skip = (17'(in_row) + 17'd1) <= 17'(VSHIFT);
    more_syn = (17'(syn_cnt) + 17'd1) < 17'(VSHIFT);
    border   = ((17'(out_h) + 17'd1) <= 17'(BORDER)) || (out_h >= H_HI) ||
               ((17'(out_v) + 17'd1) <= 17'(BORDER)) || (out_v >= V_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PASS;
      in_col    <= '0;
      in_row    <= '0;
      cnt       <= '0;
      syn_cnt   <= '0;
      out_h     <= '0;
      out_v     <= '0;
      s1_vld    <= 1'b0;
      s1_err    <= 1'b0;
      s1_data   <= '0;
      o_de      <= 1'b0;
      o_data    <= '0;
      o_pair_en <= 1'b0;
      o_sof     <= 1'b0;
      o_eol     <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      s1_vld  <= 1'b0;
      s1_err  <= 1'b0;
      s1_data <= '0;
      unique case (state)
        PASS: if (i_de) begin
          s1_vld  <= !row_skip;
          s1_data <= i_data;
          if (in_col == COL_M1) begin
            in_col <= '0;
            if (in_row == ROW_M1) begin
              in_row <= '0;
              if (VSHIFT > 0) begin
                cnt   <= '0;
                state <= (FLUSH_GAP == 0) ? FLUSH : GAP;
              end
            end else begin
              in_row <= in_row + 16'd1;
            end
          end else begin
            in_col <= in_col + 16'd1;
          end
        end
        GAP: begin
          s1_err <= i_de;
          if (cnt == GAP_M1) begin
            cnt   <= '0;
            state <= FLUSH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        FLUSH: begin
          s1_err  <= i_de;
          s1_vld  <= 1'b1;
          s1_data <= BORDER_VAL;
          if (cnt == COL_M1) begin
            cnt <= '0;
            if (more_syn) begin
              syn_cnt <= syn_cnt + 16'd1;
              state   <= (HGAP == 0) ? FLUSH : HBLK;
            end else begin
              syn_cnt <= '0;
              state   <= PASS;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HBLK: begin
          s1_err <= i_de;
          if (cnt == HGAP_M1) begin
            cnt   <= '0;
            state <= FLUSH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase

      // Output stage: position counters describe the pixel now leaving s1
      o_de  <= s1_vld;
      o_err <= s1_err;
      if (s1_vld) begin
        o_data    <= border ? BORDER_VAL : s1_data;
        o_sof     <= (out_h == '0) && (out_v == '0);
        o_eol     <= (out_h == COL_M1);
        o_pair_en <= out_h[0];
        if (out_h == COL_M1) begin
          out_h <= '0;
          out_v <= (out_v == ROW_M1) ? '0 : out_v + 16'd1;
        end else begin
          out_h <= out_h + 16'd1;
        end
      end else begin
        o_data    <= '0;
        o_sof     <= 1'b0;
        o_eol     <= 1'b0;
        o_pair_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_recenter.sv
// Bench for frame_recenter: a shifted/bordered instance and a pass-through instance
// share one stimulus; expectations come from a frame-position reference model.
module tb_frame_recenter;

  localparam int COL = 8, ROW = 6, V = 2, B = 1, FG = 4, HG = 3;
  localparam int NPIX = COL * ROW;
  localparam int MAXC = 4096;
  localparam logic [23:0] BV = '0;

  typedef struct packed {
    logic        de;
    logic [23:0] data;
    logic        sof;
    logic        eol;
    logic        pair;
    logic        err;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, i_de = 1'b0;
  logic [23:0] i_data = '0;
  logic        o_de, o_pair_en, o_sof, o_eol, o_err;
  logic [23:0] o_data;
  logic        o_de0, o_pair_en0, o_sof0, o_eol0, o_err0;
  logic [23:0] o_data0;

  frame_recenter #(.COL(COL), .ROW(ROW), .DW(24), .VSHIFT(V), .BORDER(B),
                   .FLUSH_GAP(FG), .HGAP(HG), .BORDER_VAL(BV)) dut (
    .clk(clk), .rst_n(rst_n), .i_de(i_de), .i_data(i_data),
    .o_de(o_de), .o_data(o_data), .o_pair_en(o_pair_en),
    .o_sof(o_sof), .o_eol(o_eol), .o_err(o_err));

  frame_recenter #(.COL(COL), .ROW(ROW), .DW(24), .VSHIFT(0), .BORDER(0),
                   .FLUSH_GAP(FG), .HGAP(HG), .BORDER_VAL(BV)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_de(i_de), .i_data(i_data),
    .o_de(o_de0), .o_data(o_data0), .o_pair_en(o_pair_en0),
    .o_sof(o_sof0), .o_eol(o_eol0), .o_err(o_err0));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0;
  int in_idx = 0, cnt0 = 0, busy_until = 0, last_l = 0, n_de1 = 0;
  int edge34 = 0, edge20 = 0;
  exp_t e1 [MAXC];
  exp_t e0 [MAXC];
  logic [23:0] act_data [MAXC];
  logic        act_de   [MAXC];
  logic        act_sof  [MAXC];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp)
    else begin
      errors++;
      $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Expected output pixel at output-frame index p
  function automatic exp_t pix(input int p, input logic [23:0] d, input int b);
    exp_t e;
    int h, v;
    h = p % COL;
    v = p / COL;
    e.de   = 1'b1;
    e.data = (h < b || h >= COL - b || v < b || v >= ROW - b) ? BV : d;
    e.sof  = (p == 0);
    e.eol  = (h == COL - 1);
    e.pair = h[0];
    e.err  = 1'b0;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t x1, x0;
    cyc = cyc + 1;
    #1;
    if (!rst_n) begin
      x1 = '0;
      x0 = '0;
    end else begin
      x1 = e1[cyc];
      x0 = e0[cyc];
    end
    chk("de", o_de, x1.de);
    if (x1.de) chk("data", o_data, x1.data);
    chk("sof", o_sof, x1.sof);
    chk("eol", o_eol, x1.eol);
    chk("pair", o_pair_en, x1.pair);
    chk("err", o_err, x1.err);
    chk("de0", o_de0, x0.de);
    if (x0.de) chk("data0", o_data0, x0.data);
    chk("sof0", o_sof0, x0.sof);
    chk("eol0", o_eol0, x0.eol);
    chk("pair0", o_pair_en0, x0.pair);
    chk("err0", o_err0, 1'b0);
    if (o_de) n_de1++;
    act_data[cyc] = o_data;
    act_de[cyc]   = o_de;
    act_sof[cyc]  = o_sof;
  end

  // One clock of stimulus; updates both reference models for the sampling edge
  task automatic step(input logic de, input logic [23:0] d);
    int eg;
    @(negedge clk);
    i_de   = de;
    i_data = d;
    eg     = cyc + 1;
    if (de && rst_n) begin
      e0[eg+1] = pix(cnt0, d, 0);
      cnt0 = (cnt0 + 1) % NPIX;
      if (eg <= busy_until) begin
        e1[eg+1].err = 1'b1;
      end else begin
        if (in_idx >= V * COL) e1[eg+1] = pix(in_idx - V * COL, d, B);
        in_idx++;
        if (in_idx == NPIX) begin
          in_idx = 0;
          last_l = eg;
          for (int j = 0; j < V; j++)
            for (int i = 0; i < COL; i++)
              e1[eg + FG + 2 + j * (COL + HG) + i] = pix((ROW - V + j) * COL + i, BV, B);
          busy_until = eg + FG + 1 + (V - 1) * (COL + HG) + COL - 1;
        end
      end
    end
  endtask

  task automatic send_frame(input bit pattern, input bit gaps);
    logic [23:0] d;
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step(1'b0, '0);
        d = pattern ? 24'(r * 16 + c) : 24'($urandom);
        step(1'b1, d);
        if (r == 3 && c == 4) edge34 = cyc + 1;
        if (r == 2 && c == 0) edge20 = cyc + 1;
      end
  endtask

  task automatic drain_and_count();
    while (cyc < busy_until + 4) step(1'b0, '0);
    chk("frame_pixels", 32'(n_de1), 32'(NPIX));
    n_de1 = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_de", o_de, 1'b0);
    chk("rst_data", o_data, '0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_sof", o_sof, 1'b0);
    chk("rst_pair", o_pair_en, 1'b0);
    for (int i = cyc + 1; i < MAXC; i++) begin
      e1[i] = '0;
      e0[i] = '0;
    end
    in_idx = 0;
    cnt0 = 0;
    busy_until = 0;
    n_de1 = 0;
    step(1'b0, '0);
    step(1'b0, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    int t;
    for (int i = 0; i < MAXC; i++) begin
      e1[i] = '0;
      e0[i] = '0;
    end
    repeat (3) step(1'b0, '0);
    chk("init_de", o_de, 1'b0);
    chk("init_data", o_data, '0);
    rst_n = 1'b1;
    step(1'b0, '0);

    // Frame A: row*16+col, continuous
    send_frame(1'b1, 1'b0);
    drain_and_count();
    chk("interior_de", act_de[edge34+1], 1'b1);
    chk("interior_data", act_data[edge34+1], 24'h34);

    // Frame B: random data, mid-line gaps, stray i_de in GAP and FLUSH
    send_frame(1'b0, 1'b1);
    t = last_l + 2;
    while (cyc + 2 < t) step(1'b0, '0);
    step(1'b1, 24'($urandom));
    t = last_l + FG + 3;
    while (cyc + 2 < t) step(1'b0, '0);
    step(1'b1, 24'($urandom));
    drain_and_count();

    // Frame C: reset during the second synthetic line
    send_frame(1'b0, 1'b0);
    t = last_l + FG + 2 + (COL + HG) + 3;
    while (cyc < t) step(1'b0, '0);
    chk("pre_rst_de", o_de, 1'b1);
    do_reset();

    // Frame D: restart after reset, first output is input row 2 col 0
    send_frame(1'b1, 1'b0);
    drain_and_count();
    chk("restart_sof", act_sof[edge20+1], 1'b1);
    chk("restart_data", act_data[edge20+1], BV);

    // Frame E: random data with gaps
    send_frame(1'b0, 1'b1);
    drain_and_count();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
